// File: rtl/mem_access.sv
// Load/store unit: turns one core memory request into a single bus transfer,
// aligns store lanes, extends load data and reports misalignment or timeout.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      state_q;
    logic [7:0]  tmo_q;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        load_q;

    logic        accept;
    logic        legal;
    logic        aligned;
    logic [3:0]  strb;
    logic [31:0] wlane;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    // Status and bus request are pure state decodes so reset drops them at once.
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign bus_req = (state_q == StReq);

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        accept = req_valid && (is_load ^ is_store);
        legal  = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00: begin
                strb  = 4'b0001 << addr[1:0];
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                strb  = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wlane = wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the captured request.
    always_comb begin
        case (off_q)
            2'd0:    rbyte = bus_rdata[7:0];
            2'd1:    rbyte = bus_rdata[15:8];
            2'd2:    rbyte = bus_rdata[23:16];
            default: rbyte = bus_rdata[31:24];
        endcase
        rhalf = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_ext = {24'd0, rbyte};
            3'b101:  load_ext = {16'd0, rhalf};
            default: load_ext = bus_rdata;
        endcase
    end

    // Transfer FSM with registered bus fields, result and timeout counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            tmo_q     <= 8'd0;
            off_q     <= 2'd0;
            funct3_q  <= 3'd0;
            load_q    <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        funct3_q  <= funct3;
                        off_q     <= addr[1:0];
                        load_q    <= is_load;
                        tmo_q     <= 8'd0;
                        bus_we    <= is_store;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= is_store ? strb : 4'd0;
                        bus_wdata <= is_store ? wlane : 32'd0;
                        if (legal && aligned) begin
                            state_q <= StReq;
                        end else begin
                            state_q <= StDone;
                            err     <= 1'b1;
                            rdata   <= 32'd0;
                        end
                    end
                end
                StReq: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (bus_gnt) begin
                        state_q <= StWait;
                    end else if (tmo_q == 8'd255) begin
                        state_q <= StDone;
                        err     <= 1'b1;
                        rdata   <= 32'd0;
                    end
                end
                StWait: begin
                    tmo_q <= tmo_q + 8'd1;
                    if (bus_ack) begin
                        state_q <= StDone;
                        err     <= 1'b0;
                        if (load_q) begin
                            rdata <= load_ext;
                        end
                    end else if (tmo_q == 8'd255) begin
                        state_q <= StDone;
                        err     <= 1'b1;
                        rdata   <= 32'd0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    err     <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with hand-computed expectations.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks;
    int n_fail;

    mem_access dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .is_load   (is_load),
        .is_store  (is_store),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one cycle; returns 1 ns into the cycle after acceptance.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        is_load   = ld;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        step();
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
    endtask

    initial begin
        int cyc;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        bus_gnt   = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_bus_we", 32'(bus_we), 32'd0);
        check_eq("rst_wstrb", 32'(bus_wstrb), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // lb 0x103: minimum latency, sign-extended top byte.
        bus_rdata = 32'h80FF_0000;
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0);
        check_eq("lb_bus_req", 32'(bus_req), 32'd1);
        check_eq("lb_bus_addr", bus_addr, 32'h0000_0100);
        check_eq("lb_wstrb", 32'(bus_wstrb), 32'd0);
        check_eq("lb_we", 32'(bus_we), 32'd0);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_ack = 1'b1;
        check_eq("lb_wait_no_req", 32'(bus_req), 32'd0);
        check_eq("lb_wait_done", 32'(done), 32'd0);
        step();
        bus_ack = 1'b0;
        check_eq("lb_done", 32'(done), 32'd1);
        check_eq("lb_err", 32'(err), 32'd0);
        check_eq("lb_rdata", rdata, 32'hFFFF_FF80);
        step();
        check_eq("lb_done_pulse", 32'(done), 32'd0);
        check_eq("lb_idle", 32'(busy), 32'd0);

        // sh 0x202: upper half lanes, rdata untouched.
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF);
        check_eq("sh_we", 32'(bus_we), 32'd1);
        check_eq("sh_wstrb", 32'(bus_wstrb), 32'hC);
        check_eq("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        check_eq("sh_bus_addr", bus_addr, 32'h0000_0200);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("sh_done", 32'(done), 32'd1);
        check_eq("sh_err", 32'(err), 32'd0);
        check_eq("sh_rdata_kept", rdata, 32'hFFFF_FF80);
        step();

        // sb 0x001: byte lane 1; ack in REQ must be ignored.
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5);
        check_eq("sb_wstrb", 32'(bus_wstrb), 32'h2);
        check_eq("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("sb_ack_in_req", 32'(bus_req), 32'd1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("sb_done", 32'(done), 32'd1);
        step();

        // lw 0x101: misaligned, immediate error without a bus request.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0);
        check_eq("lw_mis_bus_req", 32'(bus_req), 32'd0);
        check_eq("lw_mis_done", 32'(done), 32'd1);
        check_eq("lw_mis_err", 32'(err), 32'd1);
        check_eq("lw_mis_rdata", rdata, 32'd0);
        step();

        // Store with load-only funct3 is illegal.
        issue(1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'd0);
        check_eq("st_ill_done", 32'(done), 32'd1);
        check_eq("st_ill_err", 32'(err), 32'd1);
        step();

        // Timeout: grant never arrives.
        rdata_prime: begin
            bus_rdata = 32'h1111_2222;
            issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
            bus_gnt = 1'b1;
            step();
            bus_gnt = 1'b0;
            bus_ack = 1'b1;
            step();
            bus_ack = 1'b0;
            check_eq("lw_rdata", rdata, 32'h1111_2222);
            step();
        end
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
        cyc = 0;
        while (!done && cyc < 300) begin
            cyc++;
            step();
        end
        check_eq("tmo_busy_cycles", 32'(cyc), 32'd256);
        check_eq("tmo_done", 32'(done), 32'd1);
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_rdata", rdata, 32'd0);
        step();
        check_eq("tmo_bus_req_after", 32'(bus_req), 32'd0);
        check_eq("tmo_busy_after", 32'(busy), 32'd0);

        // lhu 0x002 with a competing request held while busy.
        bus_rdata = 32'h8001_1234;
        issue(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'd0);
        req_valid = 1'b1;
        is_store  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_0400;
        bus_gnt   = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_ack = 1'b1;
        check_eq("lhu_addr_held", bus_addr, 32'h0000_0000);
        step();
        bus_ack   = 1'b0;
        req_valid = 1'b0;
        is_store  = 1'b0;
        check_eq("lhu_done", 32'(done), 32'd1);
        check_eq("lhu_rdata", rdata, 32'h0000_8001);
        step();
        check_eq("lhu_no_second", 32'(busy), 32'd0);

        // Reset while waiting for ack.
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check_eq("rw_in_wait", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("rw_busy", 32'(busy), 32'd0);
        check_eq("rw_bus_req", 32'(bus_req), 32'd0);
        check_eq("rw_done", 32'(done), 32'd0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("rw_no_done", 32'(done), 32'd0);
        rst = 1'b1;
        step();
        check_eq("rw_still_idle", 32'(done | busy), 32'd0);

        // sw 0x600 after reset release.
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0600, 32'h1234_5678);
        check_eq("sw_wstrb", 32'(bus_wstrb), 32'hF);
        check_eq("sw_wdata", bus_wdata, 32'h1234_5678);
        check_eq("sw_we", 32'(bus_we), 32'd1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check_eq("sw_done", 32'(done), 32'd1);
        check_eq("sw_err", 32'(err), 32'd0);
        check_eq("sw_rdata", rdata, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
